// File: rtl/mips_hazard_pipeline_pkg.sv
// Shared types and constants for the load-use hazard pipeline: FSM states,
// forward-select encodings and the rs/rt field positions in an instruction.
package mips_hazard_pipeline_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam int REG_FIELD_W = 5;
    localparam int RS_MSB      = 25;
    localparam int RS_LSB      = 21;
    localparam int RT_MSB      = 20;
    localparam int RT_LSB      = 16;

endpackage

// File: rtl/mips_hazard_pipeline_fwd.sv
// Operand forwarding compare for one EX source register; the MEM result is
// newer than WB, so it wins when both stages write the same register.
module mips_fwd_unit
    import mips_hazard_pipeline_pkg::*;
#(
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] src,
    input  logic               mem_valid,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_dst,
    input  logic               wb_valid,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_dst,
    output logic [1:0]         sel
);

    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (mem_valid && mem_reg_write && (mem_dst == src)) begin
                sel = FWD_MEM;
            end else if (wb_valid && wb_reg_write && (wb_dst == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/mips_hazard_pipeline.sv
// Five-stage pipeline control: ID/EX/MEM/WB bookkeeping, load-use stall FSM
// with a LOAD_LAT-cycle hold, branch flush and EX operand forwarding selects.
module mips_hazard_pipeline
    import mips_hazard_pipeline_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int RADDR_W  = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_valid,
    input  logic [INSTR_W-1:0] if_instr,
    output logic               if_ready,
    input  logic               id_mem_read,
    input  logic               id_reg_write,
    input  logic [RADDR_W-1:0] id_dst,
    input  logic               flush,
    output logic [INSTR_W-1:0] id_instr,
    output logic               id_valid,
    output logic               ex_valid,
    output logic               mem_valid,
    output logic               wb_valid,
    output logic [RADDR_W-1:0] ex_dst,
    output logic [RADDR_W-1:0] mem_dst,
    output logic [RADDR_W-1:0] wb_dst,
    output logic [1:0]         fwd_a_sel,
    output logic [1:0]         fwd_b_sel,
    output logic               stall,
    output logic [CNT_W-1:0]   stall_count
);

    // The hazard cycle itself is the first stall cycle, so HOLD covers the
    // remaining LOAD_LAT-1 cycles and is skipped entirely when LOAD_LAT is 1.
    localparam logic [1:0] CNT_LOAD = 2'(LOAD_LAT - 1);

    state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [REG_FIELD_W-1:0] rs_field, rt_field;
    logic [RADDR_W-1:0]     id_rs, id_rt;
    logic                   hazard;

    logic               ex_mem_read, ex_reg_write;
    logic [RADDR_W-1:0] ex_rs, ex_rt;
    logic               mem_reg_write, wb_reg_write;

    assign rs_field = id_instr[RS_MSB:RS_LSB];
    assign rt_field = id_instr[RT_MSB:RT_LSB];
    assign id_rs    = RADDR_W'(rs_field);
    assign id_rt    = RADDR_W'(rt_field);

    assign hazard = id_valid && ex_valid && ex_mem_read && ex_reg_write &&
                    (ex_dst != '0) && ((ex_dst == id_rs) || (ex_dst == id_rt));

    assign if_ready = !stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hazard) begin
                    stall = 1'b1;
                    if (CNT_LOAD != 2'd0) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                // Counter holds stall cycles still owed including this one.
                stall = 1'b1;
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        endcase
        if (flush) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_instr      <= '0;
            id_valid      <= 1'b0;
            ex_valid      <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_dst        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_dst       <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_dst        <= '0;
        end else begin
            mem_valid     <= ex_valid;
            mem_reg_write <= ex_reg_write;
            mem_dst       <= ex_dst;
            wb_valid      <= mem_valid;
            wb_reg_write  <= mem_reg_write;
            wb_dst        <= mem_dst;

            // Bubbles carry zeroed fields so they never match any compare.
            if (flush || stall) begin
                ex_valid     <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_dst       <= '0;
                ex_rs        <= '0;
                ex_rt        <= '0;
            end else begin
                ex_valid     <= id_valid;
                ex_mem_read  <= id_valid && id_mem_read;
                ex_reg_write <= id_valid && id_reg_write;
                ex_dst       <= id_valid ? id_dst : '0;
                ex_rs        <= id_valid ? id_rs : '0;
                ex_rt        <= id_valid ? id_rt : '0;
            end

            if (flush) begin
                id_valid <= 1'b0;
            end else if (!stall) begin
                id_instr <= if_instr;
                id_valid <= if_valid;
            end
        end
    end

    mips_fwd_unit #(.RADDR_W(RADDR_W)) u_fwd_a (
        .src           (ex_rs),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .sel           (fwd_a_sel)
    );

    mips_fwd_unit #(.RADDR_W(RADDR_W)) u_fwd_b (
        .src           (ex_rt),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .sel           (fwd_b_sel)
    );

endmodule

// File: tb/tb_mips_hazard_pipeline.sv
// Bench for mips_hazard_pipeline: three instances (LOAD_LAT 1/3/2, the last
// with a 2-bit stall counter) driven by directed and random instruction streams.
module tb_mips_hazard_pipeline;

    localparam int NDUT = 3;
    localparam int LATS [NDUT] = '{1, 3, 2};
    localparam int CWS  [NDUT] = '{16, 16, 2};

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        flush;

    logic        id_mr     [NDUT];
    logic        id_rw     [NDUT];
    logic [4:0]  id_dst_in [NDUT];

    logic        dut_if_ready  [NDUT];
    logic [31:0] dut_id_instr  [NDUT];
    logic        dut_id_valid  [NDUT];
    logic        dut_ex_valid  [NDUT];
    logic        dut_mem_valid [NDUT];
    logic        dut_wb_valid  [NDUT];
    logic [4:0]  dut_ex_dst    [NDUT];
    logic [4:0]  dut_mem_dst   [NDUT];
    logic [4:0]  dut_wb_dst    [NDUT];
    logic [1:0]  dut_fa        [NDUT];
    logic [1:0]  dut_fb        [NDUT];
    logic        dut_stall     [NDUT];
    logic [15:0] dut_sc        [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 2;
        localparam int CW  = (g == 2) ? 2 : 16;
        logic [CW-1:0] sc_local;
        assign dut_sc[g] = 16'(sc_local);

        mips_hazard_pipeline #(
            .INSTR_W(32), .RADDR_W(5), .LOAD_LAT(LAT), .CNT_W(CW)
        ) dut (
            .clk          (clk),
            .reset        (reset),
            .if_valid     (if_valid),
            .if_instr     (if_instr),
            .if_ready     (dut_if_ready[g]),
            .id_mem_read  (id_mr[g]),
            .id_reg_write (id_rw[g]),
            .id_dst       (id_dst_in[g]),
            .flush        (flush),
            .id_instr     (dut_id_instr[g]),
            .id_valid     (dut_id_valid[g]),
            .ex_valid     (dut_ex_valid[g]),
            .mem_valid    (dut_mem_valid[g]),
            .wb_valid     (dut_wb_valid[g]),
            .ex_dst       (dut_ex_dst[g]),
            .mem_dst      (dut_mem_dst[g]),
            .wb_dst       (dut_wb_dst[g]),
            .fwd_a_sel    (dut_fa[g]),
            .fwd_b_sel    (dut_fb[g]),
            .stall        (dut_stall[g]),
            .stall_count  (sc_local)
        );
    end

    // Reference model: each stage is a record of the instruction's decoded
    // facts; stalling is tracked as "stall cycles still owed".
    logic [31:0] m_id_instr [NDUT];
    bit m_id_v [NDUT];
    bit m_ex_v [NDUT], m_ex_ld [NDUT], m_ex_wr [NDUT];
    int m_ex_dst [NDUT], m_ex_rs [NDUT], m_ex_rt [NDUT];
    bit m_mem_v [NDUT], m_mem_wr [NDUT];
    int m_mem_dst [NDUT];
    bit m_wb_v [NDUT], m_wb_wr [NDUT];
    int m_wb_dst [NDUT];
    int m_owed [NDUT];
    int m_sc [NDUT];

    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] enc_lw(input int rs, input int rt);
        return {6'h23, 5'(rs), 5'(rt), 16'h0004};
    endfunction

    function automatic logic [31:0] enc_add(input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h20};
    endfunction

    function automatic bit dec_mr(input logic [31:0] ins);
        return ins[31:26] == 6'h23;
    endfunction

    function automatic bit dec_rw(input logic [31:0] ins);
        return (ins[31:26] == 6'h23) || (ins[31:26] == 6'h00);
    endfunction

    function automatic logic [4:0] dec_dst(input logic [31:0] ins);
        return (ins[31:26] == 6'h23) ? ins[20:16] : ins[15:11];
    endfunction

    function automatic logic [31:0] rand_instr();
        int rs = int'($urandom_range(0, 7));
        int rt = int'($urandom_range(0, 7));
        int rd = int'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       return enc_lw(rs, rt);
            3:       return {6'h04, 5'(rs), 5'(rt), 16'h0010};
            default: return enc_add(rs, rt, rd);
        endcase
    endfunction

    function automatic bit m_hazard(input int k);
        int rs = int'(m_id_instr[k][25:21]);
        int rt = int'(m_id_instr[k][20:16]);
        return m_id_v[k] && m_ex_v[k] && m_ex_ld[k] && m_ex_wr[k] &&
               (m_ex_dst[k] != 0) && ((m_ex_dst[k] == rs) || (m_ex_dst[k] == rt));
    endfunction

    function automatic bit m_stall(input int k);
        return (m_owed[k] > 0) || m_hazard(k);
    endfunction

    function automatic int m_fwd(input int k, input int src);
        if (src == 0) return 0;
        if (m_mem_v[k] && m_mem_wr[k] && m_mem_dst[k] == src) return 1;
        if (m_wb_v[k] && m_wb_wr[k] && m_wb_dst[k] == src) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_id_instr[k] = '0; m_id_v[k] = 0;
            m_ex_v[k] = 0; m_ex_ld[k] = 0; m_ex_wr[k] = 0;
            m_ex_dst[k] = 0; m_ex_rs[k] = 0; m_ex_rt[k] = 0;
            m_mem_v[k] = 0; m_mem_wr[k] = 0; m_mem_dst[k] = 0;
            m_wb_v[k] = 0; m_wb_wr[k] = 0; m_wb_dst[k] = 0;
            m_owed[k] = 0; m_sc[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit ifv, input logic [31:0] ifi, input bit fl);
        bit st = m_stall(k);
        m_wb_v[k] = m_mem_v[k]; m_wb_wr[k] = m_mem_wr[k]; m_wb_dst[k] = m_mem_dst[k];
        m_mem_v[k] = m_ex_v[k]; m_mem_wr[k] = m_ex_wr[k]; m_mem_dst[k] = m_ex_dst[k];
        if (st && m_sc[k] < (1 << CWS[k]) - 1) m_sc[k]++;
        if (fl) begin
            m_owed[k] = 0;
            m_ex_v[k] = 0; m_ex_ld[k] = 0; m_ex_wr[k] = 0;
            m_id_v[k] = 0;
        end else if (st) begin
            if (m_owed[k] > 0) m_owed[k]--;
            else m_owed[k] = LATS[k] - 1;
            m_ex_v[k] = 0; m_ex_ld[k] = 0; m_ex_wr[k] = 0;
        end else begin
            m_ex_v[k]   = m_id_v[k];
            m_ex_ld[k]  = m_id_v[k] && id_mr[k];
            m_ex_wr[k]  = m_id_v[k] && id_rw[k];
            m_ex_dst[k] = int'(id_dst_in[k]);
            m_ex_rs[k]  = int'(m_id_instr[k][25:21]);
            m_ex_rt[k]  = int'(m_id_instr[k][20:16]);
            m_id_v[k]     = ifv;
            m_id_instr[k] = ifi;
        end
    endtask

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NDUT; k++) begin
            bit st = m_stall(k);
            check("stall", k, 32'(dut_stall[k]), 32'(st));
            check("if_ready", k, 32'(dut_if_ready[k]), 32'(!st));
            check("id_valid", k, 32'(dut_id_valid[k]), 32'(m_id_v[k]));
            check("ex_valid", k, 32'(dut_ex_valid[k]), 32'(m_ex_v[k]));
            check("mem_valid", k, 32'(dut_mem_valid[k]), 32'(m_mem_v[k]));
            check("wb_valid", k, 32'(dut_wb_valid[k]), 32'(m_wb_v[k]));
            check("stall_count", k, 32'(dut_sc[k]), 32'(m_sc[k]));
            if (m_id_v[k]) check("id_instr", k, dut_id_instr[k], m_id_instr[k]);
            if (m_ex_v[k]) begin
                check("ex_dst", k, 32'(dut_ex_dst[k]), 32'(m_ex_dst[k]));
                check("fwd_a", k, 32'(dut_fa[k]), 32'(m_fwd(k, m_ex_rs[k])));
                check("fwd_b", k, 32'(dut_fb[k]), 32'(m_fwd(k, m_ex_rt[k])));
            end
            if (m_mem_v[k]) check("mem_dst", k, 32'(dut_mem_dst[k]), 32'(m_mem_dst[k]));
            if (m_wb_v[k]) check("wb_dst", k, 32'(dut_wb_dst[k]), 32'(m_wb_dst[k]));
        end
    endtask

    // Drive at the falling edge, model the rising edge, compare at the next fall.
    task automatic step(input bit ifv, input logic [31:0] ifi, input bit fl);
        for (int k = 0; k < NDUT; k++) begin
            id_mr[k]     = dec_mr(m_id_instr[k]);
            id_rw[k]     = dec_rw(m_id_instr[k]);
            id_dst_in[k] = dec_dst(m_id_instr[k]);
        end
        if_valid = ifv;
        if_instr = ifi;
        flush    = fl;
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) model_step(k, ifv, ifi, fl);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int nstall [NDUT];
        int first_clear [NDUT];
        int broken [NDUT];
        logic [31:0] add5;

        reset = 1'b1; if_valid = 1'b0; if_instr = '0; flush = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            id_mr[k] = 1'b0; id_rw[k] = 1'b0; id_dst_in[k] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Load r5 followed by a consumer of r5: LOAD_LAT stall cycles each.
        add5 = enc_add(5, 2, 8);
        step(1, enc_lw(1, 5), 0);
        step(1, add5, 0);
        for (int k = 0; k < NDUT; k++) begin
            nstall[k] = 0; first_clear[k] = -1; broken[k] = 0;
        end
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NDUT; k++) begin
                if (dut_stall[k]) begin
                    if (first_clear[k] < 0) nstall[k]++;
                    else broken[k] = 1;
                end else if (first_clear[k] < 0) begin
                    first_clear[k] = i;
                end
                if (i <= LATS[k]) check("ld_use_id_hold", k, dut_id_instr[k], add5);
                if (i == LATS[k]) check("ld_use_bubble", k, 32'(dut_ex_valid[k]), 32'd0);
            end
            step(0, 32'h0, 0);
        end
        for (int k = 0; k < NDUT; k++) begin
            check("ld_use_stall_cycles", k, 32'(nstall[k]), 32'(LATS[k]));
            check("ld_use_contiguous", k, 32'(broken[k]), 32'd0);
            check("ld_use_stall_count", k, 32'(dut_sc[k]), 32'(LATS[k]));
        end

        // Load into r0 never stalls or forwards.
        step(1, enc_lw(1, 0), 0);
        step(1, enc_add(0, 2, 3), 0);
        for (int k = 0; k < NDUT; k++) check("r0_no_stall", k, 32'(dut_stall[k]), 32'd0);
        step(0, 32'h0, 0);
        for (int k = 0; k < NDUT; k++) check("r0_fwd_a", k, 32'(dut_fa[k]), 32'd0);

        // MEM and WB both write r7: MEM wins; then WB alone.
        step(1, enc_add(1, 2, 7), 0);
        step(1, enc_add(3, 4, 7), 0);
        step(1, enc_add(1, 7, 9), 0);
        step(0, 32'h0, 0);
        for (int k = 0; k < NDUT; k++) check("fwd_b_mem_prio", k, 32'(dut_fb[k]), 32'd1);
        step(1, enc_add(1, 2, 7), 0);
        step(1, 32'h0, 0);
        step(1, enc_add(1, 7, 9), 0);
        step(0, 32'h0, 0);
        for (int k = 0; k < NDUT; k++) check("fwd_b_wb", k, 32'(dut_fb[k]), 32'd2);

        // Flush in the second HOLD cycle of the LOAD_LAT=3 instance.
        step(1, enc_lw(1, 5), 0);
        step(1, add5, 0);
        step(0, 32'h0, 0);
        step(0, 32'h0, 0);
        check("flush_pre_stall", 1, 32'(dut_stall[1]), 32'd1);
        step(1, 32'h1234_5678, 1);
        for (int k = 0; k < NDUT; k++) begin
            check("flush_stall", k, 32'(dut_stall[k]), 32'd0);
            check("flush_id_valid", k, 32'(dut_id_valid[k]), 32'd0);
            check("flush_ex_valid", k, 32'(dut_ex_valid[k]), 32'd0);
        end

        // Asynchronous reset in the middle of a HOLD.
        step(1, enc_lw(1, 5), 0);
        step(1, add5, 0);
        step(0, 32'h0, 0);
        check("hold_before_reset", 1, 32'(dut_stall[1]), 32'd1);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("rst_stall", k, 32'(dut_stall[k]), 32'd0);
            check("rst_if_ready", k, 32'(dut_if_ready[k]), 32'd1);
            check("rst_id_valid", k, 32'(dut_id_valid[k]), 32'd0);
            check("rst_ex_valid", k, 32'(dut_ex_valid[k]), 32'd0);
            check("rst_mem_valid", k, 32'(dut_mem_valid[k]), 32'd0);
            check("rst_wb_valid", k, 32'(dut_wb_valid[k]), 32'd0);
            check("rst_id_instr", k, dut_id_instr[k], 32'd0);
            check("rst_dsts", k, {17'd0, dut_ex_dst[k], dut_mem_dst[k], dut_wb_dst[k]}, 32'd0);
            check("rst_fwd", k, {28'd0, dut_fa[k], dut_fb[k]}, 32'd0);
            check("rst_stall_count", k, 32'(dut_sc[k]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(0, 32'h0, 0);
        for (int k = 0; k < NDUT; k++) begin
            check("post_rst_stall", k, 32'(dut_stall[k]), 32'd0);
            check("post_rst_if_ready", k, 32'(dut_if_ready[k]), 32'd1);
        end

        // Random instruction stream with occasional redirects.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 85), rand_instr(), ($urandom_range(0, 11) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
